ysyx_22050133_ifu: RTL and testbench

//  Instruction fetch unit: producer of the 32-bit inst word consumed by the decode stage.

---
 rtl/ysyx_22050133_ifu_if.sv | 28 ++
 rtl/ysyx_22050133_ifu.sv | 152 +++++++++++++++
 tb/tb_ysyx_22050133_ifu.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050133_ifu_if.sv
// ysyx_22050133_ifu_if
//   AXI read-channel bundle (AR + R) between the instruction fetch unit and
//   instruction memory.
//   master : fetch unit side   (drives arvalid/araddr/arsize/rready)
//   slave  : memory side       (drives arready/rvalid/rdata/rresp)
`timescale 1ns/1ps
interface ysyx_22050133_ifu_if #(
  parameter int DATA_W = 64
);
  logic              arvalid;
  logic              arready;
  logic [63:0]       araddr;
  logic [2:0]        arsize;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid, araddr, arsize, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, arsize, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ysyx_22050133_ifu.sv
// ysyx_22050133_ifu
//   Instruction fetch unit. Holds the PC, issues one AXI read per instruction
//   (at most one outstanding), and presents {pc, inst, err} to IF/ID with a
//   valid/ready handshake. EX redirects replace the PC and squash stale fetches.
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_redirect_valid    single-cycle redirect pulse from EX
//   i_redirect_pc       redirect target (bits [1:0] ignored)
//   o_out_valid         o_out_pc/o_out_inst/o_out_err valid toward IF/ID
//   i_out_ready         IF/ID accepts the presented instruction
//   o_out_pc/inst/err   presented PC, instruction word, fetch error flag
//   m_axi               AXI read channel (master modport)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | one cycle after reset release, then start first fetch
// S_AR   | arvalid high, waiting for arready
// S_R    | rready high, waiting for rvalid (discard if r_drop/redirect)
// S_HOLD | instruction presented, waiting for i_out_ready or redirect
`timescale 1ns/1ps
module ysyx_22050133_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DATA_W   = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_redirect_valid,
  input  logic [63:0]                i_redirect_pc,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [63:0]                o_out_pc,
  output logic [31:0]                o_out_inst,
  output logic                       o_out_err,
  ysyx_22050133_ifu_if.master        m_axi
);

  localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_HOLD} state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_araddr;
  logic        r_drop;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_out_valid;
  logic [63:0] r_out_pc;
  logic [31:0] r_out_inst;
  logic        r_out_err;

  logic [63:0] w_redirect_pc;
  logic [63:0] w_pc_inc;
  logic [31:0] w_inst;

  assign w_redirect_pc = i_redirect_pc & ~64'h3;
  assign w_pc_inc      = r_pc + 64'd4;
  // pc[2] picks the upper or lower 32-bit lane of the 64-bit beat
  assign w_inst        = r_pc[2] ? m_axi.rdata[DATA_W-1 -: 32] : m_axi.rdata[31:0];

  assign m_axi.arvalid = r_arvalid;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arsize  = AXI_SIZE_BYTES_4;
  assign m_axi.rready  = r_rready;
  assign o_out_valid   = r_out_valid;
  assign o_out_pc      = r_out_pc;
  assign o_out_inst    = r_out_inst;
  assign o_out_err     = r_out_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_araddr    <= 64'd0;
      r_drop      <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pc    <= 64'd0;
      r_out_inst  <= 32'd0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state   <= S_AR;
          r_arvalid <= 1'b1;
          if (i_redirect_valid) begin
            r_pc     <= w_redirect_pc;
            r_araddr <= w_redirect_pc;
          end else begin
            r_araddr <= r_pc;
          end
        end
        S_AR: begin
          // araddr is its own register so a redirect cannot disturb a pending AR
          if (i_redirect_valid) begin
            r_pc   <= w_redirect_pc;
            r_drop <= 1'b1;
          end
          if (m_axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (m_axi.rvalid) begin
            r_rready <= 1'b0;
            if (r_drop || i_redirect_valid) begin
              r_drop    <= 1'b0;
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
              if (i_redirect_valid) begin
                r_pc     <= w_redirect_pc;
                r_araddr <= w_redirect_pc;
              end else begin
                r_araddr <= r_pc;
              end
            end else begin
              r_out_pc    <= r_pc;
              r_out_inst  <= w_inst;
              r_out_err   <= (m_axi.rresp != 2'b00);
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end else if (i_redirect_valid) begin
            r_pc   <= w_redirect_pc;
            r_drop <= 1'b1;
          end
        end
        S_HOLD: begin
          // a redirect wins over a same-cycle accept; EX flushes the accepted word
          if (i_redirect_valid) begin
            r_out_valid <= 1'b0;
            r_pc        <= w_redirect_pc;
            r_araddr    <= w_redirect_pc;
            r_arvalid   <= 1'b1;
            r_state     <= S_AR;
          end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_pc        <= w_pc_inc;
            r_araddr    <= w_pc_inc;
            r_arvalid   <= 1'b1;
            r_state     <= S_AR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_ifu.sv
// tb_ysyx_22050133_ifu
//   Self-checking bench for the fetch unit. A memory slave model answers AXI
//   reads from an address-derived data pattern; the reference model tracks
//   only the PC the next presented instruction must carry.
`timescale 1ns/1ps
module tb_ysyx_22050133_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] FIX_DATA = 64'h00000013_00100093;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_err;

  ysyx_22050133_ifu_if bus ();

  ysyx_22050133_ifu dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_out_valid      (out_valid),
    .i_out_ready      (out_ready),
    .o_out_pc         (out_pc),
    .o_out_inst       (out_inst),
    .o_out_err        (out_err),
    .m_axi            (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_pc;
  int          ar_mode;
  bit          r_hold;
  int          r_dmax;
  bit          fixed_mode;
  bit          s_pend, s_clr;
  logic [63:0] s_addr;
  int          s_delay;
  bit          prev_ar_wait;
  logic [63:0] prev_araddr;
  bit          prev_hold, prev_leave;
  bit          ev_ar, ev_out;
  logic [63:0] ev_ar_addr, ev_out_pc;
  logic [31:0] ev_out_inst;
  bit          ev_out_err;
  int          n_out;

  function automatic logic [31:0] f_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    logic [63:0] base;
    base = {a[63:3], 3'b000};
    if (fixed_mode) return FIX_DATA;
    return {f_word(base + 64'd4), f_word(base)};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] pc);
    logic [63:0] d;
    if (!fixed_mode) return f_word(pc);
    d = FIX_DATA;
    return pc[2] ? d[63:32] : d[31:0];
  endfunction

  function automatic bit exp_err(input logic [63:0] a);
    return a[4:2] == 3'd5;
  endfunction

  task automatic model_reset();
    exp_pc       = RESET_PC;
    s_pend       = 0;
    s_clr        = 0;
    bus.rvalid   = 1'b0;
    bus.arready  = 1'b0;
    bus.rdata    = 64'd0;
    bus.rresp    = 2'b00;
    prev_ar_wait = 0;
    prev_hold    = 0;
    prev_leave   = 0;
    ev_ar        = 0;
    ev_out       = 0;
  endtask

  // One clock: drive slave outputs, then judge what the coming posedge will do.
  task automatic step();
    if (s_clr) begin
      bus.rvalid = 1'b0;
      s_clr = 0;
    end
    case (ar_mode)
      0:       bus.arready = ($urandom_range(0, 1) == 1);
      1:       bus.arready = 1'b1;
      default: bus.arready = 1'b0;
    endcase
    if (s_pend && !bus.rvalid && !r_hold) begin
      if (s_delay == 0) begin
        bus.rvalid = 1'b1;
        bus.rdata  = mem_data(s_addr);
        bus.rresp  = exp_err(s_addr) ? 2'b10 : 2'b00;
      end else begin
        s_delay--;
      end
    end

    ev_ar = 0;
    ev_out = 0;
    if (prev_ar_wait) begin
      checks++;
      if (bus.arvalid !== 1'b1 || bus.araddr !== prev_araddr) begin
        errors++;
        $display("FAIL ar_stable: arvalid=%0b araddr=%h required arvalid=1 araddr=%h",
                 bus.arvalid, bus.araddr, prev_araddr);
      end
    end
    if (bus.arvalid === 1'b1) begin
      checks++;
      if (bus.araddr[1:0] !== 2'b00 || s_pend || bus.arsize !== 3'b010) begin
        errors++;
        $display("FAIL ar_issue: araddr=%h arsize=%0d outstanding=%0b required aligned, size 2, none outstanding",
                 bus.araddr, bus.arsize, s_pend);
      end
    end
    if (bus.arvalid === 1'b1 && bus.arready) begin
      s_pend = 1;
      s_addr = bus.araddr;
      s_delay = $urandom_range(0, r_dmax);
      ev_ar = 1;
      ev_ar_addr = bus.araddr;
    end
    prev_ar_wait = (bus.arvalid === 1'b1) && !bus.arready;
    prev_araddr  = bus.araddr;
    if (bus.rvalid && bus.rready === 1'b1) begin
      s_pend = 0;
      s_clr = 1;
    end

    if (prev_leave) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL out_drop: out_valid=%0b required 0 after accept/redirect", out_valid);
      end
    end
    if (prev_hold) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_stable: out_valid=%0b required 1 while stalled", out_valid);
      end
    end
    if (out_valid === 1'b1) begin
      checks++;
      if (out_pc !== exp_pc) begin
        errors++;
        $display("FAIL out_pc: out_pc=%h required %h", out_pc, exp_pc);
      end
      checks++;
      if (out_inst !== exp_inst(exp_pc) || out_err !== exp_err(exp_pc)) begin
        errors++;
        $display("FAIL out_data: inst=%h err=%0b required inst=%h err=%0b",
                 out_inst, out_err, exp_inst(exp_pc), exp_err(exp_pc));
      end
    end
    prev_hold  = (out_valid === 1'b1) && !out_ready && !redirect_valid;
    prev_leave = (out_valid === 1'b1) && (out_ready || redirect_valid);
    if (out_valid === 1'b1 && out_ready && !redirect_valid) begin
      ev_out = 1;
      ev_out_pc = out_pc;
      ev_out_inst = out_inst;
      ev_out_err = out_err;
      n_out++;
    end
    if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
    else if (out_valid === 1'b1 && out_ready) exp_pc = exp_pc + 64'd4;
    @(negedge clk);
  endtask

  task automatic wait_ar(input string name, input logic [63:0] want);
    int k = 0;
    step();
    while (!ev_ar && k < 200) begin
      step();
      k++;
    end
    checks++;
    if (!ev_ar) begin
      errors++;
      $display("FAIL %s: timeout waiting for AR handshake, required araddr=%h", name, want);
    end else if (ev_ar_addr !== want) begin
      errors++;
      $display("FAIL %s: araddr=%h required %h", name, ev_ar_addr, want);
    end
  endtask

  task automatic wait_out(input string name, input logic [63:0] want_pc,
                          input logic [31:0] want_inst, input bit want_err);
    int k = 0;
    step();
    while (!ev_out && k < 200) begin
      step();
      k++;
    end
    checks++;
    if (!ev_out) begin
      errors++;
      $display("FAIL %s: timeout waiting for accepted instruction, required pc=%h", name, want_pc);
    end else if (ev_out_pc !== want_pc || ev_out_inst !== want_inst || ev_out_err !== want_err) begin
      errors++;
      $display("FAIL %s: pc=%h inst=%h err=%0b required pc=%h inst=%h err=%0b",
               name, ev_out_pc, ev_out_inst, ev_out_err, want_pc, want_inst, want_err);
    end
  endtask

  task automatic pulse_redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || out_valid !== 1'b0 ||
        out_pc !== 64'd0 || out_inst !== 32'd0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: arvalid=%0b rready=%0b out_valid=%0b out_pc=%h out_inst=%h out_err=%0b required all 0",
               name, bus.arvalid, bus.rready, out_valid, out_pc, out_inst, out_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ar_mode = 1;
    r_hold = 0;
    r_dmax = 0;
    fixed_mode = 1;
    out_ready = 1'b1;
    n_out = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero_outputs("reset_state");
    rst_n = 1'b1;
    wait_ar("first_araddr", RESET_PC);
  endtask

  task automatic test_basic();
    wait_out("basic_inst0", RESET_PC, 32'h00100093, 1'b0);
    wait_ar("second_araddr", RESET_PC + 64'd4);
    wait_out("basic_inst1", RESET_PC + 64'd4, 32'h00000013, 1'b0);
    fixed_mode = 0;
  endtask

  task automatic test_hold();
    int k = 0;
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_reach: out_valid=%0b required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== exp_inst(exp_pc) || bus.arvalid !== 1'b0) begin
        errors++;
        $display("FAIL hold_stall: out_valid=%0b pc=%h inst=%h arvalid=%0b required 1 %h %h 0",
                 out_valid, out_pc, out_inst, bus.arvalid, exp_pc, exp_inst(exp_pc));
      end
      step();
    end
    out_ready = 1'b1;
    wait_out("hold_release", RESET_PC + 64'd8, exp_inst(RESET_PC + 64'd8), exp_err(RESET_PC + 64'd8));
  endtask

  task automatic test_redirect_in_r();
    int k = 0;
    ar_mode = 1;
    r_hold = 1;
    while (bus.rready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    s_delay = 0;
    r_hold = 0;
    pulse_redirect(64'h8000_0100);
    checks++;
    if (out_valid !== 1'b0 || bus.arvalid !== 1'b1) begin
      errors++;
      $display("FAIL redirect_r_discard: out_valid=%0b arvalid=%0b required 0 1", out_valid, bus.arvalid);
    end
    wait_ar("redirect_r_araddr", 64'h8000_0100);
    wait_out("redirect_r_out", 64'h8000_0100, exp_inst(64'h8000_0100), exp_err(64'h8000_0100));
  endtask

  task automatic test_redirect_in_ar();
    int k = 0;
    logic [63:0] a_old;
    ar_mode = 2;
    while (bus.arvalid !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    a_old = exp_pc;
    checks++;
    if (bus.arvalid !== 1'b1 || bus.araddr !== a_old) begin
      errors++;
      $display("FAIL redirect_ar_reach: arvalid=%0b araddr=%h required 1 %h", bus.arvalid, bus.araddr, a_old);
    end
    pulse_redirect(64'h8000_0200);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.arvalid !== 1'b1 || bus.araddr !== a_old) begin
        errors++;
        $display("FAIL redirect_ar_hold: arvalid=%0b araddr=%h required 1 %h", bus.arvalid, bus.araddr, a_old);
      end
      step();
    end
    ar_mode = 1;
    wait_ar("redirect_ar_old", a_old);
    wait_ar("redirect_ar_target", 64'h8000_0200);
    wait_out("redirect_ar_out", 64'h8000_0200, exp_inst(64'h8000_0200), exp_err(64'h8000_0200));
  endtask

  task automatic test_err();
    ar_mode = 0;
    r_dmax = 2;
    pulse_redirect(64'h8000_0414);
    wait_out("err_fetch", 64'h8000_0414, exp_inst(64'h8000_0414), 1'b1);
    wait_out("err_next", 64'h8000_0418, exp_inst(64'h8000_0418), 1'b0);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    ar_mode = 1;
    r_hold = 1;
    step();
    while (bus.rready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid_async");
    model_reset();
    r_hold = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ar("reset_mid_araddr", RESET_PC);
    wait_out("reset_mid_out", RESET_PC, exp_inst(RESET_PC), exp_err(RESET_PC));
  endtask

  task automatic test_wrap();
    pulse_redirect(64'hFFFF_FFFF_FFFF_FFFE);
    wait_out("wrap_last", 64'hFFFF_FFFF_FFFF_FFFC, exp_inst(64'hFFFF_FFFF_FFFF_FFFC), 1'b0);
    wait_out("wrap_zero", 64'd0, exp_inst(64'd0), 1'b0);
  endtask

  task automatic test_random();
    int start_n;
    start_n = n_out;
    ar_mode = 0;
    r_dmax = 3;
    for (int i = 0; i < 800; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc = {$urandom, $urandom};
      step();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (n_out - start_n < 30) begin
      errors++;
      $display("FAIL random_progress: accepted=%0d required at least 30", n_out - start_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_redirect_in_r();
    test_redirect_in_ar();
    test_err();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
